// File: rtl/i2c_slave_read_sequencer.sv
// Slave-side read sequencer: fetches bytes from a memory port and drives the byte transmitter
// and SDA ownership through each byte/ACK pair. Optional SCL timeout: I2C_SLAVE_READ_SEQ_TIMEOUT_EN.
module i2c_slave_read_sequencer #(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned MAX_BYTES      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic                  stop_detected,
   input  logic                  scl,
   input  logic                  sda_in,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [7:0]            mem_data,
   output logic                  wb_enable,
   output logic [7:0]            wb_data,
   input  logic                  wb_finish,
   output logic                  sda_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  nack_seen,
   output logic [7:0]            byte_count
`ifdef I2C_SLAVE_READ_SEQ_TIMEOUT_EN
   ,
   output logic                  timeout
`endif
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] FETCH      = 3'd1;
   localparam logic [2:0] WAIT_FALL  = 3'd2;
   localparam logic [2:0] SEND       = 3'd3;
   localparam logic [2:0] ACK_REL    = 3'd4;
   localparam logic [2:0] ACK_SAMPLE = 3'd5;
   localparam logic [2:0] END        = 3'd6;

   localparam logic [31:0] BYTE_LIMIT = 32'(MAX_BYTES);

   if (ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("i2c_slave_read_sequencer: ADDR_WIDTH must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   logic [2:0] state;
   logic       scl_last;
   logic       fall;
   logic       rise;
   logic       limit_hit;
   logic       timeout_hit;
   logic       abort;

   assign fall      = scl_last & ~scl;
   assign rise      = ~scl_last & scl;
   assign busy      = (state != IDLE);
   assign limit_hit = (BYTE_LIMIT != '0) && ((32'(byte_count) + 32'd1) == BYTE_LIMIT);
   assign abort     = busy & (stop_detected | timeout_hit);

`ifdef I2C_SLAVE_READ_SEQ_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] idle_cnt;

   assign timeout_hit = busy && (idle_cnt == TO_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= timeout_hit;
         if (!busy || fall || rise || timeout_hit) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         scl_last   <= 1'b1;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         wb_enable  <= 1'b0;
         wb_data    <= '0;
         sda_sel    <= 1'b0;
         done       <= 1'b0;
         nack_seen  <= 1'b0;
         byte_count <= '0;
      end else begin
         scl_last  <= scl;
         mem_rd    <= 1'b0;
         wb_enable <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            state   <= IDLE;
            sda_sel <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     mem_addr   <= start_addr;
                     mem_rd     <= 1'b1;
                     byte_count <= '0;
                     nack_seen  <= 1'b0;
                     state      <= FETCH;
                  end
               end
               // First FETCH cycle carries the read strobe; data is captured on the next one.
               FETCH: begin
                  if (!mem_rd) begin
                     wb_data  <= mem_data;
                     mem_addr <= mem_addr + ADDR_WIDTH'(1);
                     state    <= WAIT_FALL;
                  end
               end
               WAIT_FALL: begin
                  if (fall) begin
                     wb_enable <= 1'b1;
                     sda_sel   <= 1'b1;
                     state     <= SEND;
                  end
               end
               SEND: begin
                  if (wb_finish) begin
                     state <= ACK_REL;
                  end
               end
               ACK_REL: begin
                  if (fall) begin
                     sda_sel <= 1'b0;
                     state   <= ACK_SAMPLE;
                  end
               end
               ACK_SAMPLE: begin
                  if (rise) begin
                     if (byte_count != 8'hFF) begin
                        byte_count <= byte_count + 8'd1;
                     end
                     if (sda_in) begin
                        nack_seen <= 1'b1;
                        state     <= END;
                     end else if (limit_hit) begin
                        state <= END;
                     end else begin
                        mem_rd <= 1'b1;
                        state  <= FETCH;
                     end
                  end
               end
               END: begin
                  if (fall) begin
                     done    <= 1'b1;
                     sda_sel <= 1'b0;
                     state   <= IDLE;
                  end
               end
               default: begin
                  state   <= IDLE;
                  sda_sel <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_read_sequencer.sv
// Testbench for i2c_slave_read_sequencer: models SCL, memory, byte transmitter and master ACKs;
// two instances share stimulus (MAX_BYTES 16 and MAX_BYTES 2).
module tb_i2c_slave_read_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset_n, start, stop_detected, scl, sda_in, wb_finish;
   logic [7:0] start_addr, mem_data;

   logic [7:0] mem_addr, wb_data, byte_count;
   logic       mem_rd, wb_enable, sda_sel, busy, done, nack_seen;
   logic [7:0] mem_addr_b, wb_data_b, byte_count_b;
   logic       mem_rd_b, wb_enable_b, sda_sel_b, busy_b, done_b, nack_seen_b;
`ifdef I2C_SLAVE_READ_SEQ_TIMEOUT_EN
   logic       timeout, timeout_b;
`endif

   i2c_slave_read_sequencer #(
      .ADDR_WIDTH     (8),
      .MAX_BYTES      (16),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .start_addr    (start_addr),
      .stop_detected (stop_detected),
      .scl           (scl),
      .sda_in        (sda_in),
      .mem_addr      (mem_addr),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .wb_enable     (wb_enable),
      .wb_data       (wb_data),
      .wb_finish     (wb_finish),
      .sda_sel       (sda_sel),
      .busy          (busy),
      .done          (done),
      .nack_seen     (nack_seen),
      .byte_count    (byte_count)
`ifdef I2C_SLAVE_READ_SEQ_TIMEOUT_EN
      ,.timeout      (timeout)
`endif
   );

   i2c_slave_read_sequencer #(
      .ADDR_WIDTH     (8),
      .MAX_BYTES      (2),
      .TIMEOUT_CYCLES (64)
   ) dut_b (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .start_addr    (start_addr),
      .stop_detected (stop_detected),
      .scl           (scl),
      .sda_in        (sda_in),
      .mem_addr      (mem_addr_b),
      .mem_rd        (mem_rd_b),
      .mem_data      (mem_data),
      .wb_enable     (wb_enable_b),
      .wb_data       (wb_data_b),
      .wb_finish     (wb_finish),
      .sda_sel       (sda_sel_b),
      .busy          (busy_b),
      .done          (done_b),
      .nack_seen     (nack_seen_b),
      .byte_count    (byte_count_b)
`ifdef I2C_SLAVE_READ_SEQ_TIMEOUT_EN
      ,.timeout      (timeout_b)
`endif
   );

   logic [7:0]  mem [256];
   logic [7:0]  exp_addr_q [$];
   logic [7:0]  exp_data_q [$];
   logic [7:0]  addr_b_q [$];
   int unsigned compared, mismatched;
   int unsigned scl_cnt, tx_rises;
   int unsigned en_cnt, rd_cnt, done_cnt, to_cnt, nack_at;
   int unsigned en_cnt_b, rd_cnt_b, done_cnt_b, to_cnt_b;
   logic        scl_run, tx_active, start_pending, rd_q;
   logic [7:0]  addr_q, pend_addr;

   // One clock of bench activity: observe outputs #1 after the edge, then drive next inputs.
   task automatic tick();
      logic       next_scl;
      logic [7:0] e;
      @(posedge clock);
      #1;
      start         = 1'b0;
      stop_detected = 1'b0;
      wb_finish     = 1'b0;
      if (mem_rd === 1'b1) begin
         rd_cnt++;
         compared++;
         if (exp_addr_q.size() == 0) begin
            mismatched++;
            $display("FAIL mem_rd_addr: got read at %h, required no read", mem_addr);
         end else begin
            e = exp_addr_q.pop_front();
            if (mem_addr !== e) begin
               mismatched++;
               $display("FAIL mem_rd_addr: got %h, required %h", mem_addr, e);
            end
         end
      end
      if (rd_q === 1'b1) mem_data = mem[addr_q];
      rd_q   = mem_rd;
      addr_q = mem_addr;
      if (wb_enable === 1'b1) begin
         en_cnt++;
         compared++;
         if (exp_data_q.size() == 0) begin
            mismatched++;
            $display("FAIL wb_data: got enable with %h, required no enable", wb_data);
         end else begin
            e = exp_data_q.pop_front();
            if (wb_data !== e) begin
               mismatched++;
               $display("FAIL wb_data: got %h, required %h", wb_data, e);
            end
         end
         tx_active = 1'b1;
         tx_rises  = 0;
      end
      if (done === 1'b1) done_cnt++;
      if (mem_rd_b === 1'b1) begin
         rd_cnt_b++;
         addr_b_q.push_back(mem_addr_b);
      end
      if (wb_enable_b === 1'b1) en_cnt_b++;
      if (done_b === 1'b1) done_cnt_b++;
`ifdef I2C_SLAVE_READ_SEQ_TIMEOUT_EN
      if (timeout === 1'b1) to_cnt++;
      if (timeout_b === 1'b1) to_cnt_b++;
`endif
      if (scl_run) begin
         scl_cnt  = (scl_cnt + 1) % 8;
         next_scl = (scl_cnt < 4);
      end else begin
         next_scl = 1'b0;
      end
      if (tx_active && !scl && next_scl) begin
         tx_rises++;
         if (tx_rises == 8) begin
            wb_finish = 1'b1;
            compared++;
            if (sda_sel !== 1'b1) begin
               mismatched++;
               $display("FAIL sda_sel_bit0: got %b, required 1", sda_sel);
            end
         end else if (tx_rises == 9) begin
            compared++;
            if (sda_sel !== 1'b0) begin
               mismatched++;
               $display("FAIL sda_sel_ack: got %b, required 0", sda_sel);
            end
            tx_active = 1'b0;
         end
      end
      if (start_pending && scl_run && scl_cnt == 0) begin
         start         = 1'b1;
         start_addr    = pend_addr;
         start_pending = 1'b0;
      end
      sda_in = (nack_at != 0 && en_cnt == nack_at);
      scl    = next_scl;
   endtask

   task automatic ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic clear_tb();
      exp_addr_q.delete();
      exp_data_q.delete();
      addr_b_q.delete();
      en_cnt = 0; rd_cnt = 0; done_cnt = 0; to_cnt = 0; nack_at = 0;
      en_cnt_b = 0; rd_cnt_b = 0; done_cnt_b = 0; to_cnt_b = 0;
      tx_active = 1'b0;
      tx_rises  = 0;
   endtask

   task automatic do_start(input logic [7:0] addr);
      int unsigned k;
      k = 0;
      pend_addr     = addr;
      start_pending = 1'b1;
      while (start_pending && k < 20) begin
         tick();
         k++;
      end
      tick();
   endtask

   task automatic wait_idle(input string name);
      int unsigned k;
      k = 0;
      while ((busy !== 1'b0 || busy_b !== 1'b0) && k < 2000) begin
         tick();
         k++;
      end
      if (busy !== 1'b0 || busy_b !== 1'b0) begin
         compared++;
         mismatched++;
         $display("FAIL %s_idle: got busy after %0d cycles, required idle", name, k);
      end
   endtask

   task automatic wait_en(input int unsigned n, input string name);
      int unsigned k;
      k = 0;
      while (en_cnt < n && k < 1000) begin
         tick();
         k++;
      end
      if (en_cnt < n) begin
         compared++;
         mismatched++;
         $display("FAIL %s_enable_wait: got %0d enables, required %0d", name, en_cnt, n);
      end
   endtask

   task automatic check_drained(input string name);
      compared++;
      if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
         mismatched++;
         $display("FAIL %s_drained: got %0d reads / %0d bytes outstanding, required 0 / 0",
                  name, exp_addr_q.size(), exp_data_q.size());
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ticks(3);
      compared++;
      if ({mem_rd, wb_enable, sda_sel, busy, done, nack_seen} !== 6'b0) begin
         mismatched++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {mem_rd, wb_enable, sda_sel, busy, done, nack_seen});
      end
      compared++;
      if ({mem_addr, wb_data, byte_count} !== 24'h0) begin
         mismatched++;
         $display("FAIL reset_values: got %h, required 000000", {mem_addr, wb_data, byte_count});
      end
      reset_n = 1'b1;
      ticks(4);
   endtask

   task automatic test_single_nack();
      clear_tb();
      mem[8'h10] = 8'hA5;
      exp_addr_q.push_back(8'h10);
      exp_data_q.push_back(8'hA5);
      nack_at = 1;
      do_start(8'h10);
      wait_idle("single");
      ticks(4);
      compared++;
      if (en_cnt != 1 || rd_cnt != 1) begin
         mismatched++;
         $display("FAIL single_counts: got %0d enables %0d reads, required 1 1", en_cnt, rd_cnt);
      end
      compared++;
      if (nack_seen !== 1'b1 || byte_count !== 8'd1) begin
         mismatched++;
         $display("FAIL single_status: got nack %b count %0d, required 1 1", nack_seen, byte_count);
      end
      compared++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL single_done: got %0d done busy %b, required 1 0", done_cnt, busy);
      end
      check_drained("single");
   endtask

   task automatic test_burst();
      logic [7:0] vals [4];
      vals = '{8'h13, 8'h57, 8'h9B, 8'hDF};
      clear_tb();
      for (int unsigned i = 0; i < 4; i++) begin
         mem[i] = vals[i];
         exp_addr_q.push_back(8'(i));
         exp_data_q.push_back(vals[i]);
      end
      nack_at = 4;
      do_start(8'h00);
      wait_idle("burst");
      ticks(4);
      compared++;
      if (byte_count !== 8'd4 || nack_seen !== 1'b1) begin
         mismatched++;
         $display("FAIL burst_status: got count %0d nack %b, required 4 1", byte_count, nack_seen);
      end
      compared++;
      if (done_cnt != 1 || en_cnt != 4) begin
         mismatched++;
         $display("FAIL burst_done: got %0d done %0d enables, required 1 4", done_cnt, en_cnt);
      end
      check_drained("burst");
   endtask

   task automatic test_max_wrap();
      int unsigned k;
      clear_tb();
      mem[8'hFF] = 8'h3C;
      mem[8'h00] = 8'hC3;
      mem[8'h01] = 8'h66;
      exp_addr_q.push_back(8'hFF);
      exp_addr_q.push_back(8'h00);
      exp_addr_q.push_back(8'h01);
      exp_data_q.push_back(8'h3C);
      exp_data_q.push_back(8'hC3);
      exp_data_q.push_back(8'h66);
      do_start(8'hFF);
      k = 0;
      while (done_cnt_b == 0 && k < 1000) begin
         tick();
         k++;
      end
      compared++;
      if (done_cnt_b != 1) begin
         mismatched++;
         $display("FAIL max_done_wait: got %0d done, required 1", done_cnt_b);
      end
      stop_detected = 1'b1;
      tick();
      ticks(30);
      compared++;
      if (en_cnt_b != 2 || rd_cnt_b != 2 || done_cnt_b != 1) begin
         mismatched++;
         $display("FAIL max_counts: got %0d enables %0d reads %0d done, required 2 2 1",
                  en_cnt_b, rd_cnt_b, done_cnt_b);
      end
      compared++;
      if (addr_b_q.size() != 2 || addr_b_q[0] !== 8'hFF || addr_b_q[1] !== 8'h00) begin
         mismatched++;
         $display("FAIL wrap_addrs: got %p, required FF 00", addr_b_q);
      end
      compared++;
      if (byte_count_b !== 8'd2 || nack_seen_b !== 1'b0 || wb_data_b !== 8'hC3 || sda_sel_b !== 1'b0) begin
         mismatched++;
         $display("FAIL max_status: got count %0d nack %b data %h sda %b, required 2 0 c3 0",
                  byte_count_b, nack_seen_b, wb_data_b, sda_sel_b);
      end
      compared++;
      if (done_cnt != 0 || byte_count !== 8'd2 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL max_stop_main: got %0d done count %0d busy %b, required 0 2 0",
                  done_cnt, byte_count, busy);
      end
      check_drained("max");
   endtask

   task automatic test_stop_mid_byte();
      clear_tb();
      mem[8'h40] = 8'h11;
      mem[8'h41] = 8'h22;
      exp_addr_q.push_back(8'h40);
      exp_addr_q.push_back(8'h41);
      exp_data_q.push_back(8'h11);
      exp_data_q.push_back(8'h22);
      do_start(8'h40);
      wait_en(2, "stop");
      ticks(3);
      stop_detected = 1'b1;
      tick();
      compared++;
      if (busy !== 1'b0 || sda_sel !== 1'b0 || wb_enable !== 1'b0) begin
         mismatched++;
         $display("FAIL stop_abort: got busy %b sda %b en %b, required 0 0 0", busy, sda_sel, wb_enable);
      end
      compared++;
      if (byte_count !== 8'd1 || nack_seen !== 1'b0) begin
         mismatched++;
         $display("FAIL stop_hold: got count %0d nack %b, required 1 0", byte_count, nack_seen);
      end
      ticks(40);
      compared++;
      if (done_cnt != 0 || en_cnt != 2 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL stop_quiet: got %0d done %0d enables busy %b, required 0 2 0",
                  done_cnt, en_cnt, busy);
      end
      check_drained("stop");
   endtask

   task automatic test_start_while_busy();
      clear_tb();
      mem[8'h20] = 8'h5A;
      mem[8'h80] = 8'hEE;
      exp_addr_q.push_back(8'h20);
      exp_data_q.push_back(8'h5A);
      nack_at = 1;
      do_start(8'h20);
      wait_en(1, "busy_start");
      start_addr = 8'h80;
      start      = 1'b1;
      tick();
      wait_idle("busy_start");
      ticks(4);
      compared++;
      if (rd_cnt != 1 || byte_count !== 8'd1 || done_cnt != 1 || mem_addr !== 8'h21) begin
         mismatched++;
         $display("FAIL busy_start: got %0d reads count %0d done %0d addr %h, required 1 1 1 21",
                  rd_cnt, byte_count, done_cnt, mem_addr);
      end
      check_drained("busy_start");
   endtask

   task automatic test_stuck_scl();
      clear_tb();
      mem[8'h30] = 8'h77;
      exp_addr_q.push_back(8'h30);
      exp_data_q.push_back(8'h77);
      do_start(8'h30);
      wait_en(1, "stuck");
      ticks(3);
      scl_run = 1'b0;
      ticks(80);
`ifdef I2C_SLAVE_READ_SEQ_TIMEOUT_EN
      compared++;
      if (to_cnt != 1 || to_cnt_b != 1) begin
         mismatched++;
         $display("FAIL timeout_pulse: got %0d / %0d pulses, required 1 / 1", to_cnt, to_cnt_b);
      end
      compared++;
      if (busy !== 1'b0 || sda_sel !== 1'b0 || done_cnt != 0) begin
         mismatched++;
         $display("FAIL timeout_abort: got busy %b sda %b done %0d, required 0 0 0", busy, sda_sel, done_cnt);
      end
`else
      compared++;
      if (busy !== 1'b1 || sda_sel !== 1'b1 || busy_b !== 1'b1) begin
         mismatched++;
         $display("FAIL stuck_hold: got busy %b sda %b busy_b %b, required 1 1 1", busy, sda_sel, busy_b);
      end
      stop_detected = 1'b1;
      tick();
`endif
      scl_run = 1'b1;
      wait_idle("stuck");
      ticks(8);
      check_drained("stuck");
   endtask

   task automatic test_reset_mid();
      clear_tb();
      mem[8'h50] = 8'hE1;
      exp_addr_q.push_back(8'h50);
      exp_data_q.push_back(8'hE1);
      do_start(8'h50);
      wait_en(1, "reset_mid");
      ticks(10);
      reset_n = 1'b0;
      #1;
      compared++;
      if ({mem_rd, wb_enable, sda_sel, busy, done, nack_seen} !== 6'b0) begin
         mismatched++;
         $display("FAIL reset_mid_flags: got %b, required 000000",
                  {mem_rd, wb_enable, sda_sel, busy, done, nack_seen});
      end
      compared++;
      if ({mem_addr, wb_data, byte_count} !== 24'h0) begin
         mismatched++;
         $display("FAIL reset_mid_values: got %h, required 000000", {mem_addr, wb_data, byte_count});
      end
      reset_n = 1'b1;
      tx_active = 1'b0;
      ticks(20);
      compared++;
      if (busy !== 1'b0 || done_cnt != 0) begin
         mismatched++;
         $display("FAIL reset_mid_idle: got busy %b done %0d, required 0 0", busy, done_cnt);
      end
      check_drained("reset_mid");
   endtask

   initial begin
      compared = 0; mismatched = 0;
      reset_n = 1'b0; start = 1'b0; stop_detected = 1'b0; wb_finish = 1'b0;
      scl = 1'b1; sda_in = 1'b0; start_addr = '0; mem_data = '0;
      scl_run = 1'b1; scl_cnt = 7; start_pending = 1'b0; pend_addr = '0;
      rd_q = 1'b0; addr_q = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      clear_tb();
      test_reset();
      test_single_nack();
      test_burst();
      test_max_wrap();
      test_stop_mid_byte();
      test_start_while_busy();
      test_stuck_scl();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
